// File: rtl/monitor_verdict_serializer.sv
// Captures active monitor output cycles as timestamped frames and streams one word per active output.
// Latency: a frame captured at edge k is presented after edge k+1 when idle; throughput 1 word/cycle.
// Backpressure: m_* held stable while m_valid && !m_ready; captures into a full FIFO are dropped and counted.
module monitor_verdict_serializer #(
  parameter int NUM_OUT = 12,
  parameter int DATA_W  = 64,
  parameter int TS_W    = 32,
  parameter int DEPTH   = 8,
  parameter int IDX_W   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [NUM_OUT*DATA_W-1:0] out_data,
  input  logic [NUM_OUT-1:0]        out_aktv,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [IDX_W-1:0]          m_index,
  output logic [DATA_W-1:0]         m_value,
  output logic [TS_W-1:0]           m_time,
  output logic                      m_last,
  output logic                      overflow,
  output logic [15:0]               drop_count,
  output logic [$clog2(DEPTH):0]    fifo_level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_EMIT = 1'b1;

  typedef struct packed {
    logic [TS_W-1:0]           ts;
    logic [NUM_OUT-1:0]        mask;
    logic [NUM_OUT*DATA_W-1:0] data;
  } frame_t;

  frame_t                    mem_q [DEPTH];
  logic [PTR_W-1:0]          wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]          level_q, level_d;
  logic [TS_W-1:0]           ts_q;
  logic [0:0]                state_q, state_d;
  logic [TS_W-1:0]           f_ts_q;
  logic [NUM_OUT-1:0]        f_mask_q, f_mask_d;
  logic [NUM_OUT*DATA_W-1:0] f_data_q;
  logic                      ovf_q;
  logic [15:0]               drop_q;

  logic                      capture, full, push, drop, emit, fire, last_word, pop;
  logic [IDX_W-1:0]          sel_idx;
  logic [DATA_W-1:0]         sel_val;
  frame_t                    head, wr_frame;

  assign capture   = en & (|out_aktv);
  assign full      = (level_q == LVL_W'(DEPTH));
  // A full FIFO rejects the capture even if the head is popped on the same edge.
  assign push      = capture & ~full;
  assign drop      = capture & full;
  assign emit      = (state_q == S_EMIT);
  assign fire      = emit & m_ready;
  // Exactly one mask bit left: clearing the lowest set bit leaves nothing.
  assign last_word = ((f_mask_q & (f_mask_q - NUM_OUT'(1))) == '0);
  // Load the next frame when idle, or right after the last word so frames go back to back.
  assign pop       = (level_q != '0) & (~emit | (fire & last_word));
  assign head      = mem_q[rd_ptr_q];
  assign wr_frame  = '{ts: ts_q, mask: out_aktv, data: out_data};
  assign level_d   = level_q + LVL_W'(push) - LVL_W'(pop);

  // Lowest remaining mask bit selects the current word (ascending index order).
  always_comb begin
    sel_idx = '0;
    sel_val = '0;
    for (int k = NUM_OUT - 1; k >= 0; k--) begin
      if (f_mask_q[k]) begin
        sel_idx = IDX_W'(k);
        sel_val = f_data_q[k*DATA_W +: DATA_W];
      end
    end
  end

  // Next FSM state and remaining-mask update.
  always_comb begin
    state_d  = state_q;
    f_mask_d = f_mask_q;
    if (pop) begin
      state_d  = S_EMIT;
      f_mask_d = head.mask;
    end else if (fire) begin
      f_mask_d = f_mask_q & (f_mask_q - NUM_OUT'(1));
      if (last_word) state_d = S_IDLE;
    end
  end

  // Frame storage; contents need no reset because level/pointers gate every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_frame;
  end

  // Timestamp, FIFO bookkeeping, frame register, FSM and drop statistics.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ts_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      state_q  <= S_IDLE;
      f_ts_q   <= '0;
      f_mask_q <= '0;
      f_data_q <= '0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
    end else begin
      if (en)   ts_q     <= ts_q + TS_W'(1);
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        f_ts_q   <= head.ts;
        f_data_q <= head.data;
      end
      level_q  <= level_d;
      state_q  <= state_d;
      f_mask_q <= f_mask_d;
      if (drop) begin
        ovf_q <= 1'b1;
        if (drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
      end
    end
  end

  assign m_valid    = emit;
  assign m_index    = emit ? sel_idx : '0;
  assign m_value    = emit ? sel_val : '0;
  assign m_time     = emit ? f_ts_q : '0;
  assign m_last     = emit & last_word;
  assign overflow   = ovf_q;
  assign drop_count = drop_q;
  assign fifo_level = level_q;

endmodule

// File: tb/tb_monitor_verdict_serializer.sv
// Randomized and directed bench for monitor_verdict_serializer against a frame/word queue model.
// Inputs are driven 1 time unit after the rising edge; outputs are compared on the falling edge.
// The model tracks the stored frames and the remaining word list of the frame being emitted.
module tb_monitor_verdict_serializer;
  localparam int NUM_OUT = 12;
  localparam int DATA_W  = 64;
  localparam int TS_W    = 32;
  localparam int DEPTH   = 8;
  localparam int IDX_W   = 4;

  logic                      clk = 1'b0;
  logic                      rst = 1'b0;
  logic                      en = 1'b0;
  logic [NUM_OUT*DATA_W-1:0] out_data = '0;
  logic [NUM_OUT-1:0]        out_aktv = '0;
  logic                      m_valid;
  logic                      m_ready = 1'b0;
  logic [IDX_W-1:0]          m_index;
  logic [DATA_W-1:0]         m_value;
  logic [TS_W-1:0]           m_time;
  logic                      m_last;
  logic                      overflow;
  logic [15:0]               drop_count;
  logic [3:0]                fifo_level;

  always #5 clk = ~clk;

  monitor_verdict_serializer #(
    .NUM_OUT(NUM_OUT), .DATA_W(DATA_W), .TS_W(TS_W), .DEPTH(DEPTH), .IDX_W(IDX_W)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .out_data(out_data), .out_aktv(out_aktv),
    .m_valid(m_valid), .m_ready(m_ready), .m_index(m_index), .m_value(m_value),
    .m_time(m_time), .m_last(m_last), .overflow(overflow), .drop_count(drop_count),
    .fifo_level(fifo_level)
  );

  typedef struct packed {
    logic [3:0]  idx;
    logic [63:0] val;
    logic [31:0] tm;
    logic        last;
  } word_t;

  typedef struct packed {
    logic [31:0]  ts;
    logic [11:0]  mask;
    logic [767:0] data;
  } frame_t;

  word_t       cur[$];
  frame_t      mq[$];
  word_t       log_q[$];
  logic [31:0] mts = '0;
  logic        movf = 1'b0;
  logic [15:0] mdrop = '0;
  bit          mfull;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Expand a frame into its ordered word list.
  function automatic void load(input frame_t f);
    word_t w;
    int    n = 0;
    for (int k = 0; k < NUM_OUT; k++) if (f.mask[k]) n++;
    for (int k = 0; k < NUM_OUT; k++) begin
      if (f.mask[k]) begin
        n--;
        w.idx  = 4'(k);
        w.val  = f.data[k*64 +: 64];
        w.tm   = f.ts;
        w.last = (n == 0);
        cur.push_back(w);
      end
    end
  endfunction

  // Reference model: stored frames plus the words still to send.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur.delete();
      mq.delete();
      mts   = '0;
      movf  = 1'b0;
      mdrop = '0;
    end else begin
      mfull = (mq.size() == DEPTH);
      if (cur.size() != 0) begin
        if (m_ready) begin
          void'(cur.pop_front());
          if (cur.size() == 0 && mq.size() != 0) load(mq.pop_front());
        end
      end else if (mq.size() != 0) begin
        load(mq.pop_front());
      end
      if (en && (|out_aktv)) begin
        if (mfull) begin
          movf = 1'b1;
          if (mdrop != 16'hFFFF) mdrop = mdrop + 16'd1;
        end else begin
          mq.push_back('{ts: mts, mask: out_aktv, data: out_data});
        end
      end
      if (en) mts = mts + 32'd1;
    end
  end

  // Compare every cycle and log accepted words.
  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_valid", 64'(m_valid), 64'd0);
      chk("rst_index", 64'(m_index), 64'd0);
      chk("rst_value", m_value, 64'd0);
      chk("rst_time", 64'(m_time), 64'd0);
      chk("rst_last", 64'(m_last), 64'd0);
      chk("rst_ovf", 64'(overflow), 64'd0);
      chk("rst_drop", 64'(drop_count), 64'd0);
      chk("rst_level", 64'(fifo_level), 64'd0);
    end else begin
      chk("m_valid", 64'(m_valid), 64'(cur.size() != 0));
      if (cur.size() != 0) begin
        chk("m_index", 64'(m_index), 64'(cur[0].idx));
        chk("m_value", m_value, cur[0].val);
        chk("m_time", 64'(m_time), 64'(cur[0].tm));
        chk("m_last", 64'(m_last), 64'(cur[0].last));
      end
      chk("fifo_level", 64'(fifo_level), 64'(mq.size()));
      chk("overflow", 64'(overflow), 64'(movf));
      chk("drop_count", 64'(drop_count), 64'(mdrop));
      if (m_valid && m_ready)
        log_q.push_back('{idx: m_index, val: m_value, tm: m_time, last: m_last});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_data();
    for (int k = 0; k < NUM_OUT; k++) out_data[k*64 +: 64] = {$urandom(), $urandom()};
  endtask

  task automatic drain(input string name);
    int n = 0;
    m_ready  = 1'b1;
    out_aktv = '0;
    while ((m_valid || fifo_level != 0) && n < 400) begin
      tick();
      n++;
    end
    chk(name, 64'(m_valid || fifo_level != 0), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] tl[$];
    int          n;

    // Reset held, then released away from the edge.
    repeat (3) tick();
    rst     = 1'b1;
    en      = 1'b1;
    m_ready = 1'b1;
    repeat (5) tick();

    // Two-word frame captured with timestamp 5.
    out_aktv = 12'h005;
    out_data = '0;
    out_data[0*64 +: 64] = 64'd1;
    out_data[2*64 +: 64] = 64'hFFFF_FFFF_FFFF_FFFD;
    tick();
    out_aktv = '0;
    chk("t5_valid_capture_edge", 64'(m_valid), 64'd0);
    chk("t5_level_capture_edge", 64'(fifo_level), 64'd1);
    tick();
    chk("t5_w0_valid", 64'(m_valid), 64'd1);
    chk("t5_w0_index", 64'(m_index), 64'd0);
    chk("t5_w0_value", m_value, 64'd1);
    chk("t5_w0_time", 64'(m_time), 64'd5);
    chk("t5_w0_last", 64'(m_last), 64'd0);
    tick();
    chk("t5_w1_index", 64'(m_index), 64'd2);
    chk("t5_w1_value", m_value, 64'hFFFF_FFFF_FFFF_FFFD);
    chk("t5_w1_time", 64'(m_time), 64'd5);
    chk("t5_w1_last", 64'(m_last), 64'd1);
    tick();
    chk("t5_done_valid", 64'(m_valid), 64'd0);

    // Idle until the timestamp reaches 20, then capture one word.
    repeat (11) tick();
    out_aktv = 12'h800;
    out_data[11*64 +: 64] = 64'h1234;
    tick();
    out_aktv = '0;
    tick();
    chk("ts20_valid", 64'(m_valid), 64'd1);
    chk("ts20_time", 64'(m_time), 64'd20);
    chk("ts20_index", 64'(m_index), 64'd11);
    chk("ts20_value", m_value, 64'h1234);
    chk("ts20_last", 64'(m_last), 64'd1);
    tick();

    // All twelve outputs active with a toggling consumer.
    log_q.delete();
    out_aktv = 12'hFFF;
    for (int k = 0; k < NUM_OUT; k++) out_data[k*64 +: 64] = 64'(k + 100);
    tick();
    out_aktv = '0;
    for (int i = 0; i < 40; i++) begin
      m_ready = ~m_ready;
      tick();
    end
    drain("all12_drain");
    chk("all12_count", 64'(log_q.size()), 64'd12);
    for (int i = 0; i < log_q.size() && i < 12; i++) begin
      chk("all12_index", 64'(log_q[i].idx), 64'(i));
      chk("all12_value", log_q[i].val, 64'(i + 100));
      chk("all12_last", 64'(log_q[i].last), 64'(i == 11));
    end

    // Overflow: ten captures with the consumer stalled.
    m_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      out_aktv = 12'($urandom_range(1, 4095));
      rand_data();
      tick();
    end
    out_aktv = '0;
    chk("ovf_level", 64'(fifo_level), 64'd8);
    chk("ovf_flag", 64'(overflow), 64'd1);
    chk("ovf_drop", 64'(drop_count), 64'd1);
    chk("ovf_valid_held", 64'(m_valid), 64'd1);
    log_q.delete();
    drain("ovf_drain");
    for (int i = 0; i < log_q.size(); i++) if (log_q[i].last) tl.push_back(log_q[i].tm);
    chk("ovf_frames", 64'(tl.size()), 64'd9);
    for (int i = 1; i < tl.size(); i++) chk("ovf_ts_step", 64'(tl[i] - tl[i-1]), 64'd1);

    // Continuous single-bit frames: steady one-deep FIFO, no bubbles.
    m_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      out_aktv = 12'(1 << $urandom_range(0, 11));
      rand_data();
      tick();
      if (i >= 1) begin
        chk("cont_level", 64'(fifo_level), 64'd1);
        chk("cont_valid", 64'(m_valid), 64'd1);
        chk("cont_last", 64'(m_last), 64'd1);
      end
    end
    chk("cont_drop", 64'(drop_count), 64'd1);
    drain("cont_drain");

    // Randomized traffic against the model.
    for (int i = 0; i < 2500; i++) begin
      en       = ($urandom_range(0, 9) < 8);
      out_aktv = ($urandom_range(0, 9) < 3) ? 12'($urandom()) : 12'h000;
      m_ready  = ($urandom_range(0, 9) < 6);
      rand_data();
      tick();
    end
    en = 1'b1;
    drain("rand_drain");

    // Asynchronous reset in the middle of a twelve-word frame.
    out_aktv = 12'hFFF;
    rand_data();
    tick();
    out_aktv = '0;
    log_q.delete();
    n = 0;
    while (log_q.size() < 4 && n < 60) begin
      tick();
      n++;
    end
    chk("rst_reach_idx3", 64'(log_q.size() >= 4), 64'd1);
    rst = 1'b0;
    #1;
    chk("arst_valid", 64'(m_valid), 64'd0);
    chk("arst_level", 64'(fifo_level), 64'd0);
    chk("arst_ovf", 64'(overflow), 64'd0);
    chk("arst_drop", 64'(drop_count), 64'd0);
    chk("arst_time", 64'(m_time), 64'd0);
    tick();
    tick();
    rst      = 1'b1;
    out_aktv = 12'h001;
    out_data[0*64 +: 64] = 64'd42;
    tick();
    out_aktv = '0;
    tick();
    chk("post_rst_valid", 64'(m_valid), 64'd1);
    chk("post_rst_time", 64'(m_time), 64'd0);
    chk("post_rst_value", m_value, 64'd42);
    chk("post_rst_last", 64'(m_last), 64'd1);
    drain("post_rst_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/monitor_verdict_serializer.md
Name: monitor_verdict_serializer

Overview:
- Downstream of the generated RTLola monitor (topEntity). Consumes its per-cycle output_N / output_N_aktv vector.
- Captures each cycle with at least one active output as a timestamped frame into a small frame FIFO.
- Serializes each frame as one word per active output over a valid/ready stream, for a UART/trace packetizer.

Parameters:
- NUM_OUT, 12, number of monitor outputs.
- DATA_W, 64, width of each output value (signed, passed through unchanged).
- TS_W, 32, width of the free-running cycle timestamp.
- DEPTH, 8, frame FIFO depth in frames (power of two, ≥2).
- IDX_W, 4, width of the output index; must satisfy 2^IDX_W ≥ NUM_OUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset (0 = reset).
- en  in  1  monitor enable; gates capture and timestamp.
- out_data  in  NUM_OUT*DATA_W  concatenated monitor outputs; output k occupies bits [k*DATA_W +: DATA_W].
- out_aktv  in  NUM_OUT  per-output active flags, bit k = output_k_aktv.
- m_valid  out  1  serialized word valid.
- m_ready  in  1  consumer ready.
- m_index  out  IDX_W  output number k of the current word.
- m_value  out  DATA_W  value of output k.
- m_time  out  TS_W  capture timestamp of the frame.
- m_last  out  1  final word of the frame.
- overflow  out  1  sticky frame-drop flag.
- drop_count  out  16  dropped frames, saturating.
- fifo_level  out  $clog2(DEPTH)+1  frames currently stored.

Behaviour:
- Reset (rst=0, async assert, sync deassert externally):
  - outputs: m_valid=0, m_index=0, m_value=0, m_time=0, m_last=0, overflow=0, drop_count=0, fifo_level=0.
  - internal: timestamp=0, FSM=IDLE.
  - Reset mid-frame discards the in-flight frame and all stored frames.
- Timestamp: increments by 1 each clk edge when en=1; holds when en=0; wraps modulo 2^TS_W.
  - A frame captured at edge k carries the timestamp value sampled just before that edge.
- Capture: at an edge with en=1 and |out_aktv=1, write frame {timestamp, out_aktv, out_data}.
  - Cycles with all aktv=0 are never stored.
- Full: if the FIFO is full at that edge, the frame is dropped even if a pop happens the same edge.
  - On drop: overflow←1 (sticky until reset); drop_count+=1, saturating at 0xFFFF.
- Simultaneous push and pop when not full: both occur; fifo_level unchanged.
- FSM IDLE: if FIFO non-empty, pop the head into the frame register (timestamp, mask, data) and go to EMIT; else stay.
- FSM EMIT:
  - m_valid=1.
  - m_index = lowest set bit of the remaining mask.
  - m_value = that output's slice.
  - m_time = frame timestamp.
  - m_last=1 when exactly one mask bit remains.
  - On m_valid&&m_ready: clear that mask bit. If it was the last bit, then:
    - FIFO non-empty: pop next frame and stay in EMIT (back-to-back, no bubble).
    - Otherwise: go to IDLE with m_valid=0.
- Hold rule: while m_valid=1 and m_ready=0, all m_* signals stay stable.
- Latency: frame captured at edge k → m_valid=1 after edge k+1 when FSM is idle. Throughput is 1 word/cycle.
- en=0 stops capture only; draining continues.
- Word order within a frame: ascending output index.

Test Plan:
- Reset release, en=1, out_aktv=0 for 20 cycles → m_valid stays 0, fifo_level=0, timestamp reaches 20.
- At cycle t=5: out_aktv=12'b0000_0000_0101, out_0=1, out_2=-3, m_ready=1 → m_valid first high after edge 7. Expect two words:
  - index 0, value 1, time 5, last 0.
  - index 2, value -3 (0xFFFF_FFFF_FFFF_FFFD), time 5, last 1.
- All 12 aktv set, out_k=k+100, m_ready toggling 1/0 → 12 words in index order 0..11, values 100..111. m_* stable during stalls; last only on index 11.
- m_ready=0, then 10 consecutive active cycles with DEPTH=8:
  - 8 stored (fifo_level=8, first popped into the frame register after the first edge); expect 9 held.
  - 1 dropped → overflow=1, drop_count=1.
  - Release m_ready → 9 frames with timestamps strictly increasing by 1.
- Active capture every cycle while draining single-bit frames with m_ready=1 → continuous m_valid, m_last every word, fifo_level steady at 1, no drops.
- rst pulsed low mid-frame (after index 3 of 12) → m_valid=0 immediately (async), FIFO empty, counters 0. After release, new frame timestamps restart from 0.
